// File: rtl/serial_feeder_pkg.sv
// -----------------------------------------------------------------------------
// serial_feeder_pkg
//
// Purpose:
//   Shared definitions for the serial bit feeder. It holds the feeder state
//   type, the default word width and the frame-length helper. The rest of the
//   design uses these to agree on how many serial cycles a word occupies.
//
// Contents:
//   feeder_state_e  1-bit FSM state (IDLE, SHIFT)
//   DEFAULT_WIDTH   default number of data bits per word
//   frame_len()     serial cycles per frame for a given word width
//   FRAME_LEN       frame length for the default width
//
// Configuration:
//   SER_PARITY_EN   when defined, each frame carries one trailing even-parity
//                   bit, so a frame is WIDTH+1 cycles long instead of WIDTH.
// -----------------------------------------------------------------------------
package serial_feeder_pkg;

    // The feeder is either waiting for a word or streaming one out.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } feeder_state_e;

    localparam int DEFAULT_WIDTH = 8;

    // Number of serial cycles one accepted word occupies on ser_out.
    function automatic int frame_len(input int width);
`ifdef SER_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

    localparam int FRAME_LEN = frame_len(DEFAULT_WIDTH);

endpackage

// File: rtl/ser_shift_reg.sv
// -----------------------------------------------------------------------------
// ser_shift_reg
//
// Purpose:
//   Loadable MSB-first shift register paired with a down-counter. The counter
//   tracks how many bits of the frame remain after the one currently on the
//   MSB. 'last_o' is high while the final bit of the frame sits in the MSB.
//
// Parameters:
//   W      number of bits in one frame (shift register length), >= 2
//   CNT_W  counter width; it must hold the value W-1
//
// Ports:
//   clk          input   clock, rising edge
//   reset        input   synchronous active-high reset
//   load_i       input   load load_data_i and restart the counter at W-1
//   shift_i      input   shift left by one (zero fill) and decrement counter
//   load_data_i  input   [W-1:0] frame to load, first bit out in the MSB
//   msb_o        output  current MSB, i.e. the bit being presented
//   last_o       output  counter has reached zero (final bit of the frame)
//
// load_i has priority over shift_i. This lets the owner reload on the final
// bit of one frame without a gap before the next frame.
// -----------------------------------------------------------------------------
module ser_shift_reg #(
    parameter int W     = 8,
    parameter int CNT_W = $clog2(W + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [W-1:0] load_data_i,
    output logic         msb_o,
    output logic         last_o
);

    logic [W-1:0]     shreg_q;
    logic [W-1:0]     shreg_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next-state for the data and the counter. A load restarts the frame.
    // A shift moves the next bit into the MSB and counts down one position.
    // With neither, both hold their value.
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (load_i) begin
            shreg_d = load_data_i;
            cnt_d   = CNT_W'(W - 1);
        end else if (shift_i) begin
            shreg_d = {shreg_q[W-2:0], 1'b0};
            cnt_d   = cnt_q - CNT_W'(1);
        end
    end

    // Storage for the shift register and the counter. Reset clears both so the
    // block comes up empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign msb_o  = shreg_q[W-1];
    assign last_o = (cnt_q == '0);

endmodule

// File: rtl/serial_bit_feeder.sv
// -----------------------------------------------------------------------------
// serial_bit_feeder
//
// Purpose:
//   Parallel-to-serial front end for the single-bit sequence detector. It
//   accepts WIDTH-bit words over a valid/ready handshake and drives them
//   MSB-first on ser_out, one bit per clock. ser_valid flags each real frame
//   bit, and frame_done marks the final bit of each frame. A new word can be
//   accepted on the final bit of the current frame, so back-to-back words
//   stream with no idle cycle between them.
//
// Parameters:
//   WIDTH   data bits per word (2..32)
//   CNT_W   bit-counter width, derived from WIDTH (do not override)
//
// Ports:
//   clk         input   single clock, rising edge
//   reset       input   synchronous active-high reset
//   in_data     input   [WIDTH-1:0] word to serialize
//   in_valid    input   in_data is valid this cycle
//   in_ready    output  word accepted this cycle when in_valid is also high
//   ser_out     output  serial bit (drives the detector's x input)
//   ser_valid   output  ser_out carries a frame bit this cycle
//   frame_done  output  high during the last bit of a frame
//   busy        output  a frame is in flight
//
// Configuration:
//   SER_PARITY_EN   when defined, an even-parity bit (XOR of the word) follows
//                   the LSB as an extra frame cycle. The parity bit is computed
//                   when the word is accepted.
// -----------------------------------------------------------------------------
module serial_bit_feeder
    import serial_feeder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_done,
    output logic             busy
);

    // Serial cycles per frame: WIDTH data bits, plus one parity bit when the
    // parity feature is built in.
    localparam int FRAME = frame_len(WIDTH);

    feeder_state_e    state_q;
    feeder_state_e    state_d;

    logic             accept;
    logic             loadFrame;
    logic             shiftEn;
    logic             frameMsb;
    logic             lastBit;
    logic [FRAME-1:0] frameWord;

    // The frame image is loaded whole into the shift register. With parity,
    // the parity bit sits below the LSB so that it is shifted out last.
`ifdef SER_PARITY_EN
    assign frameWord = {in_data, ^in_data};
`else
    assign frameWord = in_data;
`endif

    // The shift register presents the current bit in its MSB. It also flags
    // the final bit of the frame through its down-counter.
    ser_shift_reg #(
        .W     (FRAME),
        .CNT_W (CNT_W)
    ) u_shift (
        .clk         (clk),
        .reset       (reset),
        .load_i      (loadFrame),
        .shift_i     (shiftEn),
        .load_data_i (frameWord),
        .msb_o       (frameMsb),
        .last_o      (lastBit)
    );

    // Ready when idle, or on the final bit of a frame so the next word can
    // follow with no gap. Ready is held low while reset is asserted, so
    // nothing is captured on the reset edge.
    assign in_ready = !reset && ((state_q == IDLE) || ((state_q == SHIFT) && lastBit));
    assign accept   = in_valid && in_ready;

    // Next-state and shift-register control. An accepted word always loads.
    // In SHIFT, a non-final bit shifts. On the final bit, the block either
    // reloads (an accept is present) or returns to IDLE.
    always_comb begin
        state_d   = state_q;
        loadFrame = 1'b0;
        shiftEn   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    loadFrame = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (lastBit) begin
                    if (accept) begin
                        loadFrame = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    shiftEn = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register. Reset abandons any frame in flight and returns to IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The outputs are decoded only from registered state, so they change only
    // on clock edges. Outside SHIFT they are all held at zero.
    always_comb begin
        ser_out    = 1'b0;
        ser_valid  = 1'b0;
        frame_done = 1'b0;
        busy       = 1'b0;
        if (state_q == SHIFT) begin
            ser_out    = frameMsb;
            ser_valid  = 1'b1;
            frame_done = lastBit;
            busy       = 1'b1;
        end
    end

endmodule

// File: doc/serial_bit_feeder.md
Name: serial_bit_feeder

Overview:
- Parallel-to-serial front end that feeds the single-bit Mealy sequence detector. Its `ser_out` drives the detector's `x` input, one bit per `clk`.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out MSB-first.
- Flags each driven bit with `ser_valid` and marks the final bit of each frame with `frame_done`.
- Supports back-to-back words with no idle bubble.

Parameters:
- WIDTH, 8, number of data bits per word (legal range 2..32).
- CNT_W, $clog2(WIDTH+1), width of the internal bit counter (derived; not overridden).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  parallel word to serialize.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block accepts in_data this cycle; transfer occurs when in_valid & in_ready.
- ser_out  output  1  serial bit to downstream (detector `x`).
- ser_valid  output  1  ser_out carries a real frame bit this cycle.
- frame_done  output  1  one-cycle pulse, high during the last bit of a frame.
- busy  output  1  high whenever a frame is in flight (state SHIFT).

Behaviour:
- Reset values (registered outputs, cleared on the edge where reset=1): ser_out=0, ser_valid=0, frame_done=0, busy=0, state=IDLE, counter=0, shift register=0.
- in_ready is combinational: (state==IDLE) | (state==SHIFT & last_bit). It is forced to 0 while reset=1.
- States:
  - IDLE: ser_valid=0, ser_out=0. On accept, load the shift register with in_data, set counter=WIDTH-1, go to SHIFT.
  - SHIFT: ser_out = shreg[WIDTH-1], ser_valid=1. Each cycle shift left by one (zero fill) and decrement the counter. last_bit = (counter==0).
- Latency: accept on edge N; the MSB appears on ser_out in the cycle after edge N. The LSB appears WIDTH-1 cycles later.
- frame_done=1 exactly during the LSB cycle (last_bit), otherwise 0.
- Last-bit cycle:
  - With an accept: reload and stay in SHIFT. The next word's MSB follows immediately, so the stream is continuous with no gap.
  - Without an accept: go to IDLE, and ser_valid drops in the next cycle.
- in_valid while not in_ready is ignored. No buffering and no data capture occur.
- Reset mid-frame: the frame is abandoned. The next cycle is IDLE with all outputs at reset values, and no frame_done is produced for the aborted frame.
- in_data is sampled only on the accepting edge. Later changes to in_data have no effect.

Optional Feature:
- Macro: SER_PARITY_EN.
- Defined:
  - After the LSB, one extra SHIFT cycle drives the even-parity bit (XOR of the accepted word) with ser_valid=1.
  - Frame length becomes WIDTH+1 cycles.
  - last_bit, frame_done and the back-to-back in_ready window move to the parity cycle.
  - The parity bit is captured on the accepting edge.
- Undefined:
  - No parity logic or parity storage.
  - Frame length is WIDTH cycles, exactly as above.

Decomposition:
- Shared package `serial_feeder_pkg` holds:
  - the state typedef (IDLE, SHIFT) as a 1-bit enum;
  - the default WIDTH constant;
  - the frame-length constant FRAME_LEN = WIDTH (+1 under SER_PARITY_EN).
- One sub-module is natural: `ser_shift_reg`. It is a loadable MSB-first shift register with a down-counter and a `last` flag, instantiated once. The FSM and handshake stay in the top.

Test Plan:
- Single word: reset 2 cycles, then WIDTH=8, in_data=8'hB5 with in_valid for one cycle. Required response:
  - ser_out = 1,0,1,1,0,1,0,1 on the next 8 cycles with ser_valid=1;
  - frame_done only on the 8th bit;
  - ser_valid=0 afterwards.
- Back-to-back: 8'hFF then 8'h00, with in_valid held. Required response: 16 consecutive ser_valid cycles, bits 1×8 then 0×8, and frame_done on cycles 8 and 16.
- Busy rejection: assert in_valid with 8'hAA during bit 3 of an 8'h0F frame. Required response: in_ready=0, the output stream stays 0,0,0,0,1,1,1,1, and 8'hAA is never emitted.
- Reset mid-frame: assert reset during bit 4 of 8'hC3. Required response:
  - next cycle ser_valid=0, ser_out=0, busy=0, no frame_done;
  - a following 8'h81 serializes correctly as 1,0,0,0,0,0,0,1.
- Detector integration: drive ser_out into the sequence detector's `x` input with a known pattern and check that the detector's `z` pulses match the golden model.
- SER_PARITY_EN build: send 8'h07. Required response: 9 valid bits 0,0,0,0,0,1,1,1,1, with frame_done on the 9th bit.
